// File: rtl/collision_engine_pkg.sv
// Shared defaults, FSM state type and the owner-id width helper for the collision engine.
package collision_engine_pkg;
  localparam int DEF_COORD_W     = 8;
  localparam int DEF_TANK_SIZE   = 8;
  localparam int DEF_BULLET_SIZE = 2;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/collision_engine_if.sv
// Frame-tick handshake, position snapshot inputs and hit results between game logic and the engine.
interface collision_engine_if import collision_engine_pkg::*; #(
  parameter int N_BULLETS = 8,
  parameter int N_TANKS   = 2,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int OWNER_W   = owner_w(N_TANKS)
);
  logic                                start;
  logic [N_TANKS-1:0][COORD_W-1:0]     tank_x, tank_y;
  logic [N_TANKS-1:0]                  tank_alive;
  logic [N_BULLETS-1:0]                bullet_active;
  logic [N_BULLETS-1:0][COORD_W-1:0]   bullet_x, bullet_y;
  logic [N_BULLETS-1:0][OWNER_W-1:0]   bullet_owner;
  logic                                busy, done;
  logic [N_TANKS-1:0]                  tank_hit;
  logic [N_TANKS-1:0][OWNER_W-1:0]     tank_hit_by;
  logic [N_BULLETS-1:0]                bullet_destroy;

  modport master (
    output start, tank_x, tank_y, tank_alive, bullet_active, bullet_x, bullet_y, bullet_owner,
    input  busy, done, tank_hit, tank_hit_by, bullet_destroy
  );
  modport slave (
    input  start, tank_x, tank_y, tank_alive, bullet_active, bullet_x, bullet_y, bullet_owner,
    output busy, done, tank_hit, tank_hit_by, bullet_destroy
  );
endinterface

// File: rtl/collision_engine_aabb.sv
// Combinational axis-aligned box overlap; box A at (ax,ay) size A_SIZE, box B at (bx,by) size B_SIZE.
module aabb_overlap #(
  parameter int COORD_W = 8,
  parameter int A_SIZE  = 2,
  parameter int B_SIZE  = 8
) (
  input  logic [COORD_W-1:0] ax, ay, bx, by,
  output logic               hit
);
  localparam logic [COORD_W:0] AS = (COORD_W+1)'(A_SIZE);
  localparam logic [COORD_W:0] BS = (COORD_W+1)'(B_SIZE);

  // One extra bit keeps boxes at the far coordinate edge from wrapping to zero.
  logic [COORD_W:0] ax_e, ay_e, bx_e, by_e;
  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  assign hit = (ax_e < bx_e + BS) && (ax_e + AS > bx_e) &&
               (ay_e < by_e + BS) && (ay_e + AS > by_e);
endmodule

// File: rtl/collision_engine.sv
// Time-multiplexed bullet/tank collision engine: snapshot on start, one bullet per cycle vs all tanks.
// Optional build macro BULLET_VS_BULLET_EN adds bullet-vs-bullet destruction during the scan.
module collision_engine import collision_engine_pkg::*; #(
  parameter int N_BULLETS   = 8,
  parameter int N_TANKS     = 2,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int TANK_SIZE   = DEF_TANK_SIZE,
  parameter int BULLET_SIZE = DEF_BULLET_SIZE,
  parameter int OWNER_W     = owner_w(N_TANKS)
) (
  input logic               clk,
  input logic               rstn,
  collision_engine_if.slave bus
);
  localparam int IDX_W = (N_BULLETS <= 2) ? 1 : $clog2(N_BULLETS);
  localparam logic [IDX_W-1:0]   LAST = IDX_W'(N_BULLETS - 1);
  localparam logic [OWNER_W:0]   NT   = (OWNER_W+1)'(N_TANKS);

  logic [N_TANKS-1:0][COORD_W-1:0]   s_tx, s_ty;
  logic [N_TANKS-1:0]                s_alive;
  logic [N_BULLETS-1:0]              s_act;
  logic [N_BULLETS-1:0][COORD_W-1:0] s_bx, s_by;
  logic [N_BULLETS-1:0][OWNER_W-1:0] s_own;

  state_t                            state;
  logic [IDX_W-1:0]                  idx;
  logic [N_TANKS-1:0]                hit_acc, hit_q;
  logic [N_TANKS-1:0][OWNER_W-1:0]   by_acc, by_q;
  logic [N_BULLETS-1:0]              des_acc, des_q, des_next, bb_hits;
  logic                              busy_q, done_q;

  logic [COORD_W-1:0] cur_x, cur_y;
  logic [OWNER_W-1:0] cur_own;
  logic               cur_ok;
  logic [N_TANKS-1:0] tank_ovl, tank_hits;

  assign cur_x   = s_bx[idx];
  assign cur_y   = s_by[idx];
  assign cur_own = s_own[idx];
  // Out-of-range shooter ids are treated as harmless.
  assign cur_ok  = s_act[idx] && ({1'b0, cur_own} < NT);

  for (genvar t = 0; t < N_TANKS; t++) begin : g_tank
    aabb_overlap #(.COORD_W(COORD_W), .A_SIZE(BULLET_SIZE), .B_SIZE(TANK_SIZE)) u_ovl (
      .ax(cur_x), .ay(cur_y), .bx(s_tx[t]), .by(s_ty[t]), .hit(tank_ovl[t])
    );
    assign tank_hits[t] = cur_ok && s_alive[t] && (cur_own != OWNER_W'(t)) && tank_ovl[t];
  end

`ifdef BULLET_VS_BULLET_EN
  logic [N_BULLETS-1:0] bb_ovl;
  for (genvar j = 0; j < N_BULLETS; j++) begin : g_bb
    aabb_overlap #(.COORD_W(COORD_W), .A_SIZE(BULLET_SIZE), .B_SIZE(BULLET_SIZE)) u_ovl (
      .ax(cur_x), .ay(cur_y), .bx(s_bx[j]), .by(s_by[j]), .hit(bb_ovl[j])
    );
    assign bb_hits[j] = (idx != IDX_W'(j)) && s_act[idx] && s_act[j] &&
                        (cur_own != s_own[j]) && bb_ovl[j];
  end
`else
  assign bb_hits = '0;
`endif

  always_comb begin
    des_next = des_acc | bb_hits;
    if ((|tank_hits) || (|bb_hits)) des_next[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;  idx <= '0;
      s_tx <= '0; s_ty <= '0; s_alive <= '0;
      s_act <= '0; s_bx <= '0; s_by <= '0; s_own <= '0;
      hit_acc <= '0; by_acc <= '0; des_acc <= '0;
      hit_q <= '0; by_q <= '0; des_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // busy_q still high here means this is the done cycle: start is ignored.
          done_q <= 1'b0;
          des_q  <= '0;
          busy_q <= 1'b0;
          if (bus.start && !busy_q) begin
            s_tx <= bus.tank_x;  s_ty <= bus.tank_y;  s_alive <= bus.tank_alive;
            s_act <= bus.bullet_active;  s_bx <= bus.bullet_x;  s_by <= bus.bullet_y;
            s_own <= bus.bullet_owner;
            hit_acc <= '0; by_acc <= '0; des_acc <= '0;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          hit_acc <= hit_acc | tank_hits;
          for (int t = 0; t < N_TANKS; t++)
            if (tank_hits[t] && !hit_acc[t]) by_acc[t] <= cur_own;
          des_acc <= des_next;
          idx     <= idx + 1'b1;
          if (idx == LAST) state <= DONE;
        end
        DONE: begin
          hit_q  <= hit_acc;
          by_q   <= by_acc;
          des_q  <= des_acc;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.tank_hit       = hit_q;
  assign bus.tank_hit_by    = by_q;
  assign bus.bullet_destroy = des_q;
endmodule

// File: tb/tb_collision_engine.sv
// Bench for collision_engine: directed vector table, multi-cycle corner sequences, random frames vs model.
module tb_collision_engine;
  localparam int NB = 4, NT = 2, CW = 8, OW = 1, TS = 8, BS = 2;

  typedef struct {
    logic [NT-1:0][CW-1:0] tx, ty;
    logic [NT-1:0]         alive;
    logic [NB-1:0]         act;
    logic [NB-1:0][CW-1:0] bx, by;
    logic [NB-1:0][OW-1:0] own;
    logic [NT-1:0]         exp_hit;
    logic [NT-1:0][OW-1:0] exp_by;
    logic [NB-1:0]         exp_des;
  } vec_t;

  logic clk = 1'b0, rstn = 1'b0;
  int pass_cnt = 0, tot_cnt = 0;

  collision_engine_if #(.N_BULLETS(NB), .N_TANKS(NT), .COORD_W(CW), .OWNER_W(OW)) ifc ();
  collision_engine #(.N_BULLETS(NB), .N_TANKS(NT), .COORD_W(CW), .TANK_SIZE(TS),
                     .BULLET_SIZE(BS), .OWNER_W(OW)) dut (.clk(clk), .rstn(rstn), .bus(ifc));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic bit ovl(input int ax, input int ay, input int asz,
                             input int bx, input int by, input int bsz);
    return (ax < bx + bsz) && (ax + asz > bx) && (ay < by + bsz) && (ay + asz > by);
  endfunction

  // Reference: walk bullets in index order, first hitter of a tank wins the credit.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_hit = '0; r.exp_by = '0; r.exp_des = '0;
    for (int b = 0; b < NB; b++) begin
      if (!v.act[b] || int'(v.own[b]) >= NT) continue;
      for (int t = 0; t < NT; t++)
        if (v.alive[t] && int'(v.own[b]) != t &&
            ovl(int'(v.bx[b]), int'(v.by[b]), BS, int'(v.tx[t]), int'(v.ty[t]), TS)) begin
          if (!r.exp_hit[t]) begin r.exp_hit[t] = 1'b1; r.exp_by[t] = v.own[b]; end
          r.exp_des[b] = 1'b1;
        end
    end
`ifdef BULLET_VS_BULLET_EN
    for (int b = 0; b < NB; b++)
      for (int j = b + 1; j < NB; j++)
        if (v.act[b] && v.act[j] && v.own[b] != v.own[j] &&
            ovl(int'(v.bx[b]), int'(v.by[b]), BS, int'(v.bx[j]), int'(v.by[j]), BS)) begin
          r.exp_des[b] = 1'b1; r.exp_des[j] = 1'b1;
        end
`endif
    return r;
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v.tx = '0; v.ty = '0; v.alive = '0; v.act = '0; v.bx = '0; v.by = '0; v.own = '0;
    v.exp_hit = '0; v.exp_by = '0; v.exp_des = '0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    ifc.tank_x = v.tx;  ifc.tank_y = v.ty;  ifc.tank_alive = v.alive;
    ifc.bullet_active = v.act;  ifc.bullet_x = v.bx;  ifc.bullet_y = v.by;
    ifc.bullet_owner = v.own;
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int k = 0;
    bit busy_ok = 1'b1;
    @(negedge clk); apply(v); ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk); ifc.start = 1'b0;
    while (k < 20 && ifc.done !== 1'b1) begin
      if (ifc.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk); k++;
    end
    if (ifc.busy !== 1'b1) busy_ok = 1'b0;
    chk({nm, ".latency"}, 32'(k), 32'(NB + 1));
    chk({nm, ".busy_during"}, 32'(busy_ok), 32'd1);
    chk({nm, ".tank_hit"}, 32'(ifc.tank_hit), 32'(v.exp_hit));
    chk({nm, ".tank_hit_by"}, 32'(ifc.tank_hit_by), 32'(v.exp_by));
    chk({nm, ".destroy"}, 32'(ifc.bullet_destroy), 32'(v.exp_des));
    @(negedge clk);
    chk({nm, ".destroy_clr"}, 32'(ifc.bullet_destroy), 32'd0);
    chk({nm, ".busy_clr"}, 32'({ifc.busy, ifc.done}), 32'd0);
    chk({nm, ".hit_held"}, 32'({ifc.tank_hit_by, ifc.tank_hit}), 32'({v.exp_by, v.exp_hit}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t v, scr;
    int k, dones, lat;
    logic [31:0] got_hit, got_by, got_des;

    v = blank(); v.tx[0] = 8; v.ty[0] = 8; v.tx[1] = 100; v.ty[1] = 100; v.alive = 2'b11;
    v.act = 4'b0001; v.bx[0] = 10; v.by[0] = 10; v.own[0] = 1;
    v.exp_hit = 2'b01; v.exp_by[0] = 1; v.exp_des = 4'b0001; tbl[0] = v;
    v.own[0] = 0; v.exp_hit = '0; v.exp_by = '0; v.exp_des = '0; tbl[1] = v;
    v = blank(); v.tx[1] = 252; v.ty[1] = 100; v.alive = 2'b11;
    v.act = 4'b0100; v.bx[2] = 253; v.by[2] = 102; v.own[2] = 0;
    v.exp_hit = 2'b10; v.exp_des = 4'b0100; tbl[2] = v;
    v = blank(); v.tx[0] = 255; v.ty[0] = 255; v.alive = 2'b11;
    v.act = 4'b0010; v.bx[1] = 255; v.by[1] = 255; v.own[1] = 1;
    v.exp_hit = 2'b01; v.exp_by[0] = 1; v.exp_des = 4'b0010; tbl[3] = v;
    v = tbl[0]; v.alive = 2'b10; v.exp_hit = '0; v.exp_by = '0; v.exp_des = '0; tbl[4] = v;
    v = tbl[0]; v.act = 4'b1001; v.bx[3] = 105; v.by[3] = 99; v.own[3] = 0;
    v.exp_hit = 2'b11; v.exp_by[0] = 1; v.exp_by[1] = 0; v.exp_des = 4'b1001; tbl[5] = v;
    v = tbl[0]; v.act = 4'b0111; v.bx[0] = 6; v.by[0] = 8; v.bx[1] = 16; v.by[1] = 8;
    v.bx[2] = 15; v.by[2] = 15; v.own = '1; v.exp_hit = 2'b01; v.exp_by[0] = 1;
    v.exp_des = 4'b0100; tbl[6] = v;
    v = blank(); v.tx[1] = 100; v.ty[1] = 100; v.alive = 2'b11; v.act = 4'b0011;
    v.bx[0] = 50; v.by[0] = 50; v.own[0] = 0; v.bx[1] = 50; v.by[1] = 50; v.own[1] = 1;
`ifdef BULLET_VS_BULLET_EN
    v.exp_des = 4'b0011;
`endif
    tbl[7] = v;

    ifc.start = 1'b0; apply(blank());
    repeat (3) @(negedge clk);
    chk("reset.outputs", 32'({ifc.busy, ifc.done, ifc.tank_hit, ifc.tank_hit_by, ifc.bullet_destroy}), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Inputs scrambled and start held high through the scan: snapshot wins, one done only.
    scr = tbl[5]; scr.tx[0] = 200; scr.own = '0;
    @(negedge clk); apply(tbl[0]); ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk); apply(scr);
    dones = 0; lat = -1; got_hit = '0; got_by = '0; got_des = '0;
    for (k = 0; k < 16; k++) begin
      if (ifc.done === 1'b1) begin
        dones++; lat = k;
        got_hit = 32'(ifc.tank_hit); got_by = 32'(ifc.tank_hit_by); got_des = 32'(ifc.bullet_destroy);
      end
      if (k == NB + 2) ifc.start = 1'b0;
      @(negedge clk);
    end
    chk("snap.done_count", 32'(dones), 32'd1);
    chk("snap.latency", 32'(lat), 32'(NB + 1));
    chk("snap.tank_hit", got_hit, 32'(tbl[0].exp_hit));
    chk("snap.tank_hit_by", got_by, 32'(tbl[0].exp_by));
    chk("snap.destroy", got_des, 32'(tbl[0].exp_des));

    // Async reset in the middle of a scan (bullet index 2 under evaluation).
    run_frame(tbl[5], "pre_rst");
    @(negedge clk); apply(tbl[0]); ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk); ifc.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.busy_before", 32'(ifc.busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst.outputs", 32'({ifc.busy, ifc.done, ifc.tank_hit, ifc.tank_hit_by, ifc.bullet_destroy}), 32'd0);
    @(negedge clk); rstn = 1'b1;
    run_frame(tbl[0], "post_rst");

    for (int n = 0; n < 40; n++) begin
      int base;
      base = ($urandom_range(0, 2) == 0) ? 232 : 0;
      v = blank();
      for (int t = 0; t < NT; t++) begin
        v.tx[t] = CW'(base + $urandom_range(0, 23));
        v.ty[t] = CW'(base + $urandom_range(0, 23));
        v.alive[t] = ($urandom_range(0, 3) != 0);
      end
      for (int b = 0; b < NB; b++) begin
        v.act[b] = ($urandom_range(0, 3) != 0);
        v.bx[b]  = CW'(base + $urandom_range(0, 23));
        v.by[b]  = CW'(base + $urandom_range(0, 23));
        v.own[b] = OW'($urandom_range(0, NT - 1));
      end
      run_frame(model(v), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
